mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 SHALL have one clock, clk; reset is synchronous and active-high.
REQ-004 SHALL have ports `clk  in  1  clock` and `reset  in  1  synchronous active-high reset`.
REQ-005 SHALL have, for N in {0,1}, the request inputs `reqN_valid 1`, `reqN_write 1`, `reqN_size 2` (00 byte, 01 half, 10 word, 11 reserved), `reqN_addr ADDR_W` and `reqN_wdata DATA_W`.
REQ-006 SHALL have, for N in {0,1}, the outputs `reqN_ready 1` (grant, one-cycle pulse), `rspN_valid 1`, `rspN_err 1` and `rspN_rdata DATA_W`.
REQ-007 SHALL drive data memory through the outputs `mem_addr ADDR_W`, `mem_we 1`, `mem_size 2` and `mem_wdata DATA_W`, and SHALL take the input `mem_rdata DATA_W` (synchronous read, valid one cycle after mem_addr).

Function
REQ-008 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-009 SHALL, in IDLE with any reqN_valid, pick a winner, pulse that reqN_ready in the same cycle, latch write/size/addr/wdata/port, and leave IDLE.
REQ-010 SHALL use round-robin selection when both requests are valid: winner is the port not granted last; after reset port 0 wins the first tie.
REQ-011 SHALL grant a lone valid request in the same cycle regardless of round-robin state.
REQ-012 SHALL flag a latched request misaligned when size=10 with addr[1:0]!=0, size=01 with addr[0]!=0, or size=11.
REQ-013 SHALL go IDLE->ACCESS for an aligned request, driving mem_addr/mem_size/mem_wdata from the latched values for one cycle, with mem_we=1 only for writes.
REQ-014 SHALL go IDLE->RESP directly for a misaligned request, with no memory cycle and mem_we held 0.
REQ-015 SHALL go ACCESS->RESP unconditionally.
REQ-016 SHALL, in RESP, assert rspN_valid for exactly one cycle on the latched port only.
REQ-016a SHALL, in RESP, set rspN_rdata=mem_rdata for aligned reads and 0 otherwise, and set rspN_err=misaligned; then go to IDLE.
REQ-017 SHALL give fixed latency of grant at T, mem access at T+1 and response at T+2 (misaligned: response at T+1); peak throughput is one transaction per 3 cycles.
REQ-018 SHALL pulse reqN_ready only in IDLE; requesters hold valid and payload stable until ready; the arbiter ignores requests outside IDLE.
REQ-019 SHALL keep mem_we=0 in every state except ACCESS-with-write.
REQ-020 SHALL keep mem_addr/mem_size/mem_wdata at their last latched values outside ACCESS.
REQ-021 SHALL allow a request granted in IDLE one cycle after RESP (back-to-back), with round-robin updated by the previous grant.

Reset
REQ-022 SHALL, while reset=1, set the state to IDLE, all ready/rsp_valid/rsp_err to 0, mem_we to 0, mem_addr/mem_wdata/rspN_rdata/mem_size to 0, and last-grant so that port 0 wins.
REQ-023 SHALL, on reset asserted in ACCESS or RESP, abort the transaction: no response is issued and mem_we is 0 from the next edge.

Configuration
REQ-024 SHALL, when MEM_ARB_FIXED_PRIORITY_EN is defined, always give port 0 ties (no round-robin, last-grant register removed).
REQ-025 SHALL, when MEM_ARB_FIXED_PRIORITY_EN is undefined, follow REQ-010.

Structure
REQ-026 SHALL place the state enum, size encodings (SIZE_BYTE/HALF/WORD/RSVD) and the port-id typedef in package mem_arb_pkg.
REQ-027 SHALL hold the two-way selection logic in sub-module mem_arb_picker (inputs valid[1:0] and last_grant; output grant one-hot).

Verification
REQ-028 SHALL verify a single read: req0 word read addr 0x10 with mem_rdata 0xDEADBEEF -> ready0 at T, mem_addr=0x10 with mem_we=0 at T+1, rsp0_valid=1 with rdata 0xDEADBEEF and err=0 at T+2.
REQ-029 SHALL verify a tie: both ports valid from reset, writes -> grants in order 0,1,0,1; with MEM_ARB_FIXED_PRIORITY_EN -> 0,0,0.
REQ-030 SHALL verify misalignment: req1 word write addr 0x13 -> rsp1_valid=1 with err=1 at T+1, mem_we never 1; size=11 at addr 0x0 -> err=1.
REQ-031 SHALL verify a halfword write: req1 addr 0x22 wdata 0x1234 size 01 -> mem_we=1 for exactly one cycle, mem_size=01, rsp1_valid at T+2 with rdata 0.
REQ-032 SHALL verify reset mid-access: reset asserted in ACCESS -> no rsp_valid, mem_we=0 next cycle, port 0 wins the next tie.
REQ-033 SHALL verify back-to-back: req0 held valid continuously -> grants every 3 cycles, never two responses in consecutive cycles.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port data-memory arbiter: FSM states, access sizes,
// port ids and the alignment check applied to a granted request.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  // The reserved size never reaches memory, so it is treated as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = |addr_lo;
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port of the arbiter.
// slave: the arbiter side; master: the requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0_valid, req1_valid;
  logic              req0_write, req1_write;
  logic [1:0]        req0_size,  req1_size;
  logic [ADDR_W-1:0] req0_addr,  req1_addr;
  logic [DATA_W-1:0] req0_wdata, req1_wdata;
  logic              req0_ready, req1_ready;
  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_err,   rsp1_err;
  logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_write, req0_size, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_size, req1_addr, req1_wdata,
    input  mem_rdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_err, rsp0_rdata,
    output rsp1_valid, rsp1_err, rsp1_rdata,
    output mem_addr, mem_we, mem_size, mem_wdata
  );

  modport master (
    output req0_valid, req0_write, req0_size, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_size, req1_addr, req1_wdata,
    output mem_rdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_err, rsp0_rdata,
    input  rsp1_valid, rsp1_err, rsp1_rdata,
    input  mem_addr, mem_we, mem_size, mem_wdata
  );
endinterface

// File: rtl/mem_arb_picker.sv
// Two-way request picker: a lone request wins outright, a tie goes to the
// port that was not granted last. Output grant is one-hot or zero.
module mem_arb_picker
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  port_t      last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = (last_grant == PORT0) ? 2'b10 : 2'b01;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port data-memory arbiter: grant -> one memory cycle -> response.
// Define MEM_ARB_FIXED_PRIORITY_EN to make port 0 win every tie.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  logic              wr_q,    wr_d;
  logic [1:0]        size_q,  size_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  port_t             port_q,  port_d;
  logic              mis_q,   mis_d;
  port_t             last_grant;
  logic [1:0]        req_valid;
  logic [1:0]        grant;
  logic              sel;
  logic              sel_write;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              resp;

  // Requests are only visible to the picker in IDLE and out of reset.
  assign req_valid = {bus.req1_valid, bus.req0_valid} & {2{(state_q == IDLE) && !reset}};

  mem_arb_picker u_picker (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  assign last_grant = PORT1;
`else
  port_t last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (|grant) last_grant_d = grant[1] ? PORT1 : PORT0;
  end

  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= PORT1;
    else       last_grant_q <= last_grant_d;
  end

  assign last_grant = last_grant_q;
`endif

  assign sel       = grant[1];
  assign sel_write = sel ? bus.req1_write : bus.req0_write;
  assign sel_size  = sel ? bus.req1_size  : bus.req0_size;
  assign sel_addr  = sel ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = sel ? bus.req1_wdata : bus.req0_wdata;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    port_d  = port_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          wr_d    = sel_write;
          size_d  = sel_size;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          port_d  = sel ? PORT1 : PORT0;
          mis_d   = is_misaligned(sel_size, sel_addr[1:0]);
          state_d = mis_d ? RESP : ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      port_q  <= PORT0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      port_q  <= port_d;
      mis_q   <= mis_d;
    end
  end

  // Memory bus simply mirrors the latched request; only mem_we is qualified.
  assign bus.mem_addr  = addr_q;
  assign bus.mem_size  = size_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = !reset && (state_q == ACCESS) && wr_q;

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  assign resp           = !reset && (state_q == RESP);
  assign bus.rsp0_valid = resp && (port_q == PORT0);
  assign bus.rsp1_valid = resp && (port_q == PORT1);
  assign bus.rsp0_err   = bus.rsp0_valid && mis_q;
  assign bus.rsp1_err   = bus.rsp1_valid && mis_q;
  assign bus.rsp0_rdata = (bus.rsp0_valid && !wr_q && !mis_q) ? bus.mem_rdata : '0;
  assign bus.rsp1_rdata = (bus.rsp1_valid && !wr_q && !mis_q) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, ties, read, misalignment,
// halfword write, reset mid-access and back-to-back grants.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: only 0x10 holds 0xDEADBEEF.
  always @(posedge clk)
    bus.mem_rdata <= (bus.mem_addr == 32'h10) ? 32'hDEADBEEF : 32'h0BAD0BAD;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_reqs();
    bus.req0_valid = 0; bus.req0_write = 0; bus.req0_size = 0; bus.req0_addr = 0; bus.req0_wdata = 0;
    bus.req1_valid = 0; bus.req1_write = 0; bus.req1_size = 0; bus.req1_addr = 0; bus.req1_wdata = 0;
  endtask

  task automatic set_req(input int p, input logic wr, input logic [1:0] sz,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (p == 0) begin
      bus.req0_valid = 1; bus.req0_write = wr; bus.req0_size = sz; bus.req0_addr = a; bus.req0_wdata = wd;
    end else begin
      bus.req1_valid = 1; bus.req1_write = wr; bus.req1_size = sz; bus.req1_addr = a; bus.req1_wdata = wd;
    end
  endtask

  initial begin
    int   w;
    logic prev_rsp;
    clr_reqs();

    // Reset state, with both writers already waiting
    set_req(0, 1, SIZE_WORD, 32'h40, 32'hA0);
    set_req(1, 1, SIZE_WORD, 32'h44, 32'hB1);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
    chk("rst_rsp_err", {bus.rsp1_err, bus.rsp0_err}, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_size", bus.mem_size, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_rdata", {bus.rsp1_rdata, bus.rsp0_rdata}, 0);

    // Tie from reset: 0,1,0,1 (fixed priority: always 0)
    @(negedge clk);
    reset = 0;
    #1;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      w = 0;
`else
      w = k % 2;
`endif
      chk($sformatf("tie%0d_ready0", k), bus.req0_ready, (w == 0));
      chk($sformatf("tie%0d_ready1", k), bus.req1_ready, (w == 1));
      @(negedge clk);
      if (k == 3) clr_reqs();
      #1;
      chk($sformatf("tie%0d_mem_we", k), bus.mem_we, 1);
      chk($sformatf("tie%0d_mem_addr", k), bus.mem_addr, (w == 0) ? 32'h40 : 32'h44);
      chk($sformatf("tie%0d_mem_wdata", k), bus.mem_wdata, (w == 0) ? 32'hA0 : 32'hB1);
      @(negedge clk);
      #1;
      chk($sformatf("tie%0d_rsp0", k), bus.rsp0_valid, (w == 0));
      chk($sformatf("tie%0d_rsp1", k), bus.rsp1_valid, (w == 1));
      chk($sformatf("tie%0d_mem_we_off", k), bus.mem_we, 0);
      if (k < 3) begin
        @(negedge clk);
        #1;
      end
    end
    @(negedge clk);

    // Single word read from port 0
    @(negedge clk);
    set_req(0, 0, SIZE_WORD, 32'h10, 32'h0);
    #1;
    chk("rd_ready0", bus.req0_ready, 1);
    chk("rd_ready1", bus.req1_ready, 0);
    @(negedge clk);
    clr_reqs();
    #1;
    chk("rd_mem_addr", bus.mem_addr, 32'h10);
    chk("rd_mem_we", bus.mem_we, 0);
    chk("rd_ready_hold", bus.req0_ready, 0);
    @(negedge clk);
    #1;
    chk("rd_rsp0_valid", bus.rsp0_valid, 1);
    chk("rd_rsp1_valid", bus.rsp1_valid, 0);
    chk("rd_rdata", bus.rsp0_rdata, 32'hDEADBEEF);
    chk("rd_err", bus.rsp0_err, 0);
    @(negedge clk);
    #1;
    chk("rd_rsp_once", bus.rsp0_valid, 0);

    // Misaligned word write on port 1: response at T+1, no memory write
    @(negedge clk);
    set_req(1, 1, SIZE_WORD, 32'h13, 32'hCAFE);
    #1;
    chk("mis_ready1", bus.req1_ready, 1);
    chk("mis_we_t0", bus.mem_we, 0);
    @(negedge clk);
    clr_reqs();
    #1;
    chk("mis_rsp1_valid", bus.rsp1_valid, 1);
    chk("mis_rsp1_err", bus.rsp1_err, 1);
    chk("mis_rsp1_rdata", bus.rsp1_rdata, 0);
    chk("mis_we_t1", bus.mem_we, 0);
    @(negedge clk);
    #1;
    chk("mis_rsp_once", bus.rsp1_valid, 0);
    chk("mis_we_t2", bus.mem_we, 0);

    // Reserved size at aligned address
    @(negedge clk);
    set_req(0, 0, SIZE_RSVD, 32'h0, 32'h0);
    #1;
    chk("rsvd_ready0", bus.req0_ready, 1);
    @(negedge clk);
    clr_reqs();
    #1;
    chk("rsvd_rsp0_valid", bus.rsp0_valid, 1);
    chk("rsvd_rsp0_err", bus.rsp0_err, 1);
    @(negedge clk);

    // Halfword write on port 1
    @(negedge clk);
    set_req(1, 1, SIZE_HALF, 32'h22, 32'h1234);
    #1;
    chk("hw_ready1", bus.req1_ready, 1);
    @(negedge clk);
    clr_reqs();
    #1;
    chk("hw_mem_we", bus.mem_we, 1);
    chk("hw_mem_size", bus.mem_size, 2'b01);
    chk("hw_mem_addr", bus.mem_addr, 32'h22);
    chk("hw_mem_wdata", bus.mem_wdata, 32'h1234);
    @(negedge clk);
    #1;
    chk("hw_we_once", bus.mem_we, 0);
    chk("hw_rsp1_valid", bus.rsp1_valid, 1);
    chk("hw_rsp1_rdata", bus.rsp1_rdata, 0);
    chk("hw_rsp1_err", bus.rsp1_err, 0);
    chk("hw_mem_size_hold", bus.mem_size, 2'b01);
    @(negedge clk);

    // Reset asserted during the ACCESS of a port-0 write
    @(negedge clk);
    set_req(0, 1, SIZE_WORD, 32'h10, 32'h55);
    #1;
    chk("rma_ready0", bus.req0_ready, 1);
    @(negedge clk);
    clr_reqs();
    #1;
    chk("rma_access_we", bus.mem_we, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    set_req(0, 0, SIZE_WORD, 32'h10, 32'h0);
    set_req(1, 0, SIZE_WORD, 32'h10, 32'h0);
    #1;
    chk("rma_no_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 0);
    chk("rma_we_off", bus.mem_we, 0);
    chk("rma_tie_ready0", bus.req0_ready, 1);
    chk("rma_tie_ready1", bus.req1_ready, 0);
    @(negedge clk);
    clr_reqs();
    #1;
    chk("rma_mem_addr", bus.mem_addr, 32'h10);
    @(negedge clk);
    #1;
    chk("rma_rsp0", bus.rsp0_valid, 1);
    chk("rma_rdata", bus.rsp0_rdata, 32'hDEADBEEF);

    // Back-to-back: port 0 held valid, grant every third cycle
    prev_rsp = 1'b0;
    @(negedge clk);
    set_req(0, 0, SIZE_WORD, 32'h10, 32'h0);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("b2b%0d_ready0", i), bus.req0_ready, (i % 3 == 0));
      chk($sformatf("b2b%0d_rsp0", i), bus.rsp0_valid, (i % 3 == 2));
      chk($sformatf("b2b%0d_consec", i), prev_rsp && bus.rsp0_valid, 0);
      if (i % 3 == 2) chk($sformatf("b2b%0d_rdata", i), bus.rsp0_rdata, 32'hDEADBEEF);
      prev_rsp = bus.rsp0_valid;
    end
    clr_reqs();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
